// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that serialises two simple register requesters onto one
// AXI-Lite master, keeping at most one transaction outstanding.
module regfile_arbiter #(
  parameter int AXI_LITE_ADDR_WIDTH = 8
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic                           req_0,
  input  logic                           we_0,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] addr_0,
  input  logic [31:0]                    wdata_0,
  output logic                           ack_0,
  output logic [31:0]                    rdata_0,
  output logic                           err_0,
  input  logic                           req_1,
  input  logic                           we_1,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] addr_1,
  input  logic [31:0]                    wdata_1,
  output logic                           ack_1,
  output logic [31:0]                    rdata_1,
  output logic                           err_1,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_araddr,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  input  logic [31:0]                    m_rdata,
  input  logic [1:0]                     m_rresp,
  input  logic                           m_rvalid,
  output logic                           m_rready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_awaddr,
  output logic                           m_awvalid,
  input  logic                           m_awready,
  output logic [31:0]                    m_wdata,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  input  logic [1:0]                     m_bresp,
  input  logic                           m_bvalid,
  output logic                           m_bready
);
  localparam int AW = AXI_LITE_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_e;

  state_e               state_q, state_d;
  logic [1:0]           req, we_in;
  logic [1:0][AW-1:0]   addr_in;
  logic [1:0][31:0]     wdata_in;
  logic                 pick;
  logic                 gnt_q, gnt_d, last_q, last_d, we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 arvalid_q, arvalid_d, rready_q, rready_d;
  logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [1:0]           ack_q, ack_d, err_q, err_d;
  logic [1:0][31:0]     rdata_q, rdata_d;

  assign req      = {req_1, req_0};
  assign we_in    = {we_1, we_0};
  assign addr_in  = {addr_1, addr_0};
  assign wdata_in = {wdata_1, wdata_0};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    ack_d     = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    // On a tie the requester not granted last wins; otherwise the lone requester.
    pick      = (req == 2'b11) ? ~last_q : req[1];
    unique case (state_q)
      IDLE: if (|req) begin
        gnt_d   = pick;
        last_d  = pick;
        we_d    = we_in[pick];
        addr_d  = addr_in[pick];
        wdata_d = wdata_in[pick];
        if (we_in[pick]) begin
          state_d   = WRITE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = RADDR;
          arvalid_d = 1'b1;
        end
      end
      RADDR: if (m_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RDATA;
      end
      RDATA: if (m_rvalid) begin
        rready_d       = 1'b0;
        state_d        = DONE;
        ack_d[gnt_q]   = 1'b1;
        rdata_d[gnt_q] = m_rdata;
        err_d[gnt_q]   = |m_rresp;
      end
      WRITE: begin
        // Address and data channels retire independently, in either order.
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: if (m_bvalid) begin
        bready_d     = 1'b0;
        state_d      = DONE;
        ack_d[gnt_q] = 1'b1;
        err_d[gnt_q] = |m_bresp;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
    gnt_q   <= gnt_d;
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign ack_0     = ack_q[0];
  assign ack_1     = ack_q[1];
  assign rdata_0   = rdata_q[0];
  assign rdata_1   = rdata_q[1];
  assign err_0     = err_q[0];
  assign err_1     = err_q[1];
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: transaction-level model with a per-cycle compare
// process, a configurable AXI-Lite slave, and directed scenarios.
module tb_regfile_arbiter;
  logic        aclk;
  logic        reset;
  logic        req_b [2];
  logic        we_b [2];
  logic [7:0]  addr_b [2];
  logic [31:0] wdata_b [2];
  logic        ack_0, ack_1, err_0, err_1;
  logic [31:0] rdata_0, rdata_1;
  logic [7:0]  m_araddr, m_awaddr;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic        m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
  logic [31:0] m_rdata = 0, m_wdata;
  logic [1:0]  m_rresp = 0, m_bresp = 0;

  regfile_arbiter #(.AXI_LITE_ADDR_WIDTH(8)) dut (
    .aclk(aclk), .reset(reset),
    .req_0(req_b[0]), .we_0(we_b[0]), .addr_0(addr_b[0]), .wdata_0(wdata_b[0]),
    .ack_0(ack_0), .rdata_0(rdata_0), .err_0(err_0),
    .req_1(req_b[1]), .we_1(we_b[1]), .addr_1(addr_b[1]), .wdata_1(wdata_b[1]),
    .ack_1(ack_1), .rdata_1(rdata_1), .err_1(err_1),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  typedef struct packed {
    logic        who;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  resp;
  } txn_t;

  txn_t        exp_q [$];
  int          grant_log [$];
  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  int          model_last = 1;
  int          n_chk = 0, n_pass = 0;
  int          aw_cycles = 0, w_cycles = 0, rready_cycles = 0;
  logic [7:0]  last_araddr = 0;
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0]  rresp_k = 0, bresp_k = 0;

  function automatic logic [31:0] init_word(input int a);
    return (a == 4) ? 32'hFF38FF9C : 32'h1000_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic push_txn(input logic who, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [1:0] resp);
    txn_t t;
    t.who = who; t.we = we; t.addr = a; t.wdata = d; t.resp = resp;
    exp_q.push_back(t);
  endtask

  // Requester: raise request, hold until ack seen, drop; lat counts IDLE..DONE cycles.
  task automatic run_req(input int n, input logic we, input logic [7:0] a,
                         input logic [31:0] d, output int lat);
    int t;
    @(negedge aclk);
    req_b[n] = 1'b1; we_b[n] = we; addr_b[n] = a; wdata_b[n] = d;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!(n == 0 ? ack_0 : ack_1) && t < 100);
    if (t >= 100) check("req_timeout", 32'(t), 32'd0);
    req_b[n] = 1'b0;
    lat = t + 1;
  endtask

  // AXI-Lite slave with per-channel wait knobs, reset by the same signal.
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    logic [7:0] s_araddr, s_awaddr;
    logic [31:0] s_wdata;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    s_araddr = 0; s_awaddr = 0; s_wdata = 0;
    forever begin
      @(negedge aclk);
      if (reset) begin
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      end else begin
        if (m_arvalid) begin ar_c++; s_araddr = m_araddr; m_arready = (ar_c > ar_wait); end
        else begin ar_c = 0; m_arready = 0; end
        if (m_rready) begin
          r_c++;
          if (r_c > r_wait) begin m_rvalid = 1; m_rdata = slave_mem[s_araddr]; m_rresp = rresp_k; end
        end else begin r_c = 0; m_rvalid = 0; end
        if (m_awvalid) begin aw_c++; s_awaddr = m_awaddr; m_awready = (aw_c > aw_wait); end
        else begin aw_c = 0; m_awready = 0; end
        if (m_wvalid) begin w_c++; s_wdata = m_wdata; m_wready = (w_c > w_wait); end
        else begin w_c = 0; m_wready = 0; end
        if (m_bready) begin
          b_c++;
          if (b_c > b_wait && !m_bvalid) begin
            m_bvalid = 1; m_bresp = bresp_k; slave_mem[s_awaddr] = s_wdata;
          end
        end else begin b_c = 0; m_bvalid = 0; end
      end
    end
  end

  // Compare process: checks the DUT against the transaction model every cycle.
  initial begin
    txn_t t;
    logic who;
    exp_rdata[0] = 0; exp_rdata[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    forever begin
      @(negedge aclk);
      #3;
      if (reset) begin
        exp_q.delete();
        exp_rdata[0] = 0; exp_rdata[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
        model_last = 1;
      end else begin
        if (ack_0 && ack_1) check("dual_ack", 32'({ack_1, ack_0}), 32'd1);
        else if (ack_0 || ack_1) begin
          who = ack_1;
          if (exp_q.size() == 0) check("spurious_ack", 32'({ack_1, ack_0}), 32'd0);
          else begin
            t = exp_q.pop_front();
            check("ack_who", 32'(who), 32'(t.who));
            grant_log.push_back(int'(who));
            model_last = int'(t.who);
            if (t.we) model_mem[t.addr] = t.wdata;
            else exp_rdata[t.who] = model_mem[t.addr];
            exp_err[t.who] = (t.resp != 2'b00);
          end
        end
        check("rdata_0", rdata_0, exp_rdata[0]);
        check("rdata_1", rdata_1, exp_rdata[1]);
        check("err_pair", 32'({err_1, err_0}), 32'({exp_err[1], exp_err[0]}));
        if (m_arvalid && m_arready) begin
          last_araddr = m_araddr;
          if (exp_q.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
          else check("ar_addr_rd", 32'({exp_q[0].we, m_araddr}), 32'({1'b0, exp_q[0].addr}));
        end
        if (m_awvalid && m_awready) begin
          if (exp_q.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
          else check("aw_addr_wr", 32'({exp_q[0].we, m_awaddr}), 32'({1'b1, exp_q[0].addr}));
        end
        if (m_wvalid && m_wready) begin
          if (exp_q.size() == 0) check("w_unexpected", 32'd1, 32'd0);
          else check("wdata", m_wdata, exp_q[0].wdata);
        end
        if (exp_q.size() == 0)
          check("idle_axi", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'd0);
        if (m_awvalid) aw_cycles++;
        if (m_wvalid) w_cycles++;
        if (m_rready) rready_cycles++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, lat1, mark, ones, order;
    int cnt [2];
    int w, idx;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      req_b[i] = 0; we_b[i] = 0; addr_b[i] = 0; wdata_b[i] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = init_word(i);
      slave_mem[i] = init_word(i);
    end
    repeat (3) @(negedge aclk);
    reset = 0;
    #1;
    check("rst_acks", 32'({ack_1, ack_0}), 32'd0);
    check("rst_rdata_0", rdata_0, 32'd0);
    check("rst_rdata_1", rdata_1, 32'd0);
    check("rst_errs", 32'({err_1, err_0}), 32'd0);
    check("rst_axi", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'd0);

    // Zero-wait read of 0x04.
    push_txn(0, 0, 8'h04, 0, 2'b00);
    run_req(0, 0, 8'h04, 0, lat);
    #1;
    check("rd_rdata_0", rdata_0, 32'hFF38FF9C);
    check("rd_err_0", 32'(err_0), 32'd0);
    check("rd_araddr", 32'(last_araddr), 32'h04);
    check("rd_latency", lat, 4);

    // Write then read back through requester 1.
    mark = grant_log.size();
    push_txn(1, 1, 8'h0C, 32'hDEADBEEF, 2'b00);
    run_req(1, 1, 8'h0C, 32'hDEADBEEF, lat);
    push_txn(1, 0, 8'h0C, 0, 2'b00);
    run_req(1, 0, 8'h0C, 0, lat);
    #1;
    check("wr_rd_rdata_1", rdata_1, 32'hDEADBEEF);
    repeat (2) @(negedge aclk);
    ones = 0;
    for (int i = mark; i < grant_log.size(); i++) if (grant_log[i] == 1) ones++;
    check("wr_rd_ack1_count", ones, 2);

    // Tie from reset: both requesters pending, two transactions each.
    @(negedge aclk);
    reset = 1;
    mark = grant_log.size();
    fork
      begin
        repeat (2) @(negedge aclk);
        reset = 0;
        cnt[0] = 2; cnt[1] = 2;
        for (int k = 0; k < 4; k++) begin
          w = (cnt[0] > 0 && cnt[1] > 0) ? 1 - model_last : (cnt[0] > 0 ? 0 : 1);
          idx = 2 - cnt[w];
          push_txn(w[0], 0, 8'(8'h10 + 8'(w) * 8'h10 + 8'(idx) * 8'h04), 0, 2'b00);
          model_last = w;
          cnt[w]--;
        end
      end
      begin run_req(0, 0, 8'h10, 0, lat0); run_req(0, 0, 8'h14, 0, lat0); end
      begin run_req(1, 0, 8'h20, 0, lat1); run_req(1, 0, 8'h24, 0, lat1); end
    join
    repeat (2) @(negedge aclk);
    order = 0;
    for (int i = mark; i < grant_log.size(); i++) order = (order << 1) | grant_log[i];
    check("tie_order", order, 32'b0101);
    check("tie_count", grant_log.size() - mark, 4);

    // Split write: address accepted first, data two cycles later.
    aw_wait = 0; w_wait = 2; aw_cycles = 0; w_cycles = 0;
    push_txn(0, 1, 8'h30, 32'hCAFEF00D, 2'b00);
    run_req(0, 1, 8'h30, 32'hCAFEF00D, lat);
    check("split_aw_cycles", aw_cycles, 1);
    check("split_w_cycles", w_cycles, 3);
    // Reversed order, with a slow and erroring write response.
    aw_wait = 3; w_wait = 0; b_wait = 2; bresp_k = 2'b01; aw_cycles = 0; w_cycles = 0;
    push_txn(1, 1, 8'h34, 32'h12345678, 2'b01);
    run_req(1, 1, 8'h34, 32'h12345678, lat);
    #1;
    check("rev_aw_cycles", aw_cycles, 4);
    check("rev_w_cycles", w_cycles, 1);
    check("wr_err_1", 32'(err_1), 32'd1);
    aw_wait = 0; b_wait = 0; bresp_k = 2'b00;

    // Slow read with SLVERR.
    r_wait = 5; rresp_k = 2'b10; rready_cycles = 0;
    push_txn(0, 0, 8'h04, 0, 2'b10);
    run_req(0, 0, 8'h04, 0, lat);
    #1;
    check("stall_err_0", 32'(err_0), 32'd1);
    check("stall_rdata_0", rdata_0, 32'hFF38FF9C);
    check("stall_rready_cycles", rready_cycles, 6);
    check("stall_latency", lat, 9);
    r_wait = 0; rresp_k = 2'b00;

    // Reset while waiting in the read data phase.
    r_wait = 50;
    push_txn(0, 0, 8'h08, 0, 2'b00);
    @(negedge aclk);
    req_b[0] = 1; we_b[0] = 0; addr_b[0] = 8'h08;
    lat = 0;
    do begin @(negedge aclk); lat++; end while (!m_rready && lat < 20);
    check("midrst_reached_rdata", 32'(m_rready), 32'd1);
    reset = 1; req_b[0] = 0;
    @(negedge aclk);
    #1;
    check("midrst_axi", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'd0);
    check("midrst_acks", 32'({ack_1, ack_0}), 32'd0);
    check("midrst_rdata_0", rdata_0, 32'd0);
    reset = 0;
    r_wait = 0;
    repeat (3) @(negedge aclk);
    push_txn(0, 0, 8'h04, 0, 2'b00);
    run_req(0, 0, 8'h04, 0, lat);
    #1;
    check("post_rst_rdata_0", rdata_0, 32'hFF38FF9C);
    check("post_rst_latency", lat, 4);

    repeat (3) @(negedge aclk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
